pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period, high time and normalised duty cycle on the same resolution scale the PWM generator consumes (R-bit resolution, duty range 0..2^R). It sits next to the PWM generator and closes the loop: the generator's output, or any external PWM source, is fed back as `pwm_in` for self-test, servo or fan-tach style measurement. Stuck-high and stuck-low inputs are reported via timeout.

---
 rtl/pwm_capture.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and R-bit normalised duty of pwm_in; reports stuck inputs after TMO clocks.
// Optional 3-sample glitch filter after the synchroniser: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int R   = 8,
  parameter int CW  = 32,
  parameter int TMO = 2500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic [R:0]    duty,
  output logic          valid,
  output logic          stalled,
  output logic          ovr
);

  localparam int IW  = $clog2(TMO + 1);
  localparam int DCW = $clog2(R + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};
  localparam logic [IW-1:0]  IDLE_MAX  = IW'(TMO);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(R);
  localparam logic [R:0]     DUTY_FULL = {1'b1, {R{1'b0}}};

  // One restoring step: returns {quotient bit, new remainder}. The remainder
  // always stays below den, so the low CW bits of the difference are exact.
  function automatic logic [CW:0] div_step(input logic [CW-1:0] rem,
                                           input logic          bit_in,
                                           input logic [CW-1:0] den);
    logic [CW:0] trial;
    trial = {rem, bit_in};
    if (trial >= {1'b0, den}) begin
      div_step = {1'b1, trial[CW-1:0] - den};
    end else begin
      div_step = {1'b0, trial[CW-1:0]};
    end
  endfunction

  logic sync1_q, sync2_q;
  logic level_q, level_d;
  logic rise_q, rise_d, fall_q, fall_d;

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic hist1_q, hist2_q;

  // Filtered level follows the input only after three equal samples in a row.
  always_comb begin
    if (sync2_q && hist1_q && hist2_q) begin
      level_d = 1'b1;
    end else if (!sync2_q && !hist1_q && !hist2_q) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
  end

  // Sample history for the filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end
`else
  // Unfiltered: the synchronised sample is the level.
  always_comb begin
    level_d = sync2_q;
  end
`endif

  // Edge strobes derived from the level seen this cycle versus last cycle.
  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Synchroniser, level and edge-strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, hi_cnt_q, hi_cnt_d, cnt_inc_s;
  logic [IW-1:0] idle_q, idle_d;
  logic          stall_hit_s, done_per_s;

  // Measurement FSM: cnt_q equals the clocks elapsed since the last rise.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cnt_d    = hi_cnt_q;
    done_per_s  = 1'b0;
    cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    stall_hit_s = (state_q != ST_STALL) && !rise_q && (idle_q == IDLE_MAX);
    if (rise_q) begin
      idle_d = IW'(1);
    end else if (idle_q == IDLE_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IW'(1);
    end
    if (stall_hit_s) begin
      state_d  = ST_STALL;
      cnt_d    = '0;
      hi_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_STALL: begin
          if (rise_q) begin
            state_d = ST_HIGH;
            cnt_d   = CW'(1);
          end else begin
            cnt_d    = '0;
            hi_cnt_d = '0;
          end
        end
        ST_HIGH: begin
          cnt_d = cnt_inc_s;
          if (fall_q) begin
            state_d  = ST_LOW;
            hi_cnt_d = cnt_q;
          end else begin
            state_d = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (rise_q) begin
            state_d    = ST_HIGH;
            cnt_d      = CW'(1);
            done_per_s = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM, counter and idle-timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_cnt_q <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_cnt_q <= hi_cnt_d;
      idle_q   <= idle_d;
    end
  end

  logic           div_busy_q, div_busy_d, div_hold_q, div_hold_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]  div_rem_q, div_rem_d, div_den_q, div_den_d;
  logic [CW-1:0]  div_per_q, div_per_d, div_hi_q, div_hi_d;
  logic [R:0]     div_num_q, div_num_d;
  logic [R-1:0]   div_quo_q, div_quo_d;
  logic [CW:0]    step_s;
  logic [R:0]     quo_next_s;
  logic           start_s, drop_s, div_done_s;

  // Divider: numerator high<<R; its upper part (high>>1) seeds the remainder
  // and the low R+1 bits are shifted in MSB first. The hold cycle after
  // completion keeps the minimum accepted period at R+3 clocks.
  always_comb begin
    div_busy_d = div_busy_q;
    div_hold_d = 1'b0;
    div_cnt_d  = div_cnt_q;
    div_rem_d  = div_rem_q;
    div_den_d  = div_den_q;
    div_num_d  = div_num_q;
    div_quo_d  = div_quo_q;
    div_per_d  = div_per_q;
    div_hi_d   = div_hi_q;
    div_done_s = 1'b0;
    start_s    = done_per_s && !div_busy_q && !div_hold_q;
    drop_s     = done_per_s && (div_busy_q || div_hold_q);
    step_s     = div_step(div_rem_q, div_num_q[R], div_den_q);
    quo_next_s = {div_quo_q, step_s[CW]};
    if (stall_hit_s) begin
      div_busy_d = 1'b0;
    end else if (start_s) begin
      div_busy_d = 1'b1;
      div_cnt_d  = '0;
      div_rem_d  = {1'b0, hi_cnt_q[CW-1:1]};
      div_num_d  = {hi_cnt_q[0], {R{1'b0}}};
      div_den_d  = cnt_q;
      div_quo_d  = '0;
      div_per_d  = cnt_q;
      div_hi_d   = hi_cnt_q;
    end else if (div_busy_q) begin
      div_rem_d = step_s[CW-1:0];
      div_num_d = {div_num_q[R-1:0], 1'b0};
      div_quo_d = quo_next_s[R-1:0];
      div_cnt_d = div_cnt_q + DCW'(1);
      if (div_cnt_q == DIV_LAST) begin
        div_busy_d = 1'b0;
        div_hold_d = 1'b1;
        div_done_s = 1'b1;
      end else begin
        div_busy_d = 1'b1;
      end
    end else begin
      div_busy_d = 1'b0;
    end
  end

  // Divider registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy_q <= 1'b0;
      div_hold_q <= 1'b0;
      div_cnt_q  <= '0;
      div_rem_q  <= '0;
      div_den_q  <= '0;
      div_num_q  <= '0;
      div_quo_q  <= '0;
      div_per_q  <= '0;
      div_hi_q   <= '0;
    end else begin
      div_busy_q <= div_busy_d;
      div_hold_q <= div_hold_d;
      div_cnt_q  <= div_cnt_d;
      div_rem_q  <= div_rem_d;
      div_den_q  <= div_den_d;
      div_num_q  <= div_num_d;
      div_quo_q  <= div_quo_d;
      div_per_q  <= div_per_d;
      div_hi_q   <= div_hi_d;
    end
  end

  logic [CW-1:0] period_q, period_d, high_time_q, high_time_d;
  logic [R:0]    duty_q, duty_d;
  logic          valid_q, valid_d, stalled_q, stalled_d, ovr_q, ovr_d;

  // Result selection: a stall report takes priority over a divider result.
  always_comb begin
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    ovr_d       = drop_s;
    if (stall_hit_s) begin
      stalled_d = 1'b1;
    end else if (rise_q) begin
      stalled_d = 1'b0;
    end else begin
      stalled_d = stalled_q;
    end
    if (stall_hit_s) begin
      valid_d  = 1'b1;
      period_d = CW'(TMO);
      if (level_q) begin
        high_time_d = CW'(TMO);
        duty_d      = DUTY_FULL;
      end else begin
        high_time_d = '0;
        duty_d      = '0;
      end
    end else if (div_done_s) begin
      valid_d     = 1'b1;
      period_d    = div_per_q;
      high_time_d = div_hi_q;
      duty_d      = quo_next_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
      ovr_q       <= ovr_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign stalled   = stalled_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of clean waveforms plus stall, overrun, reset and glitch sequences.
module tb_pwm_capture;
  localparam int R   = 8;
  localparam int CW  = 32;
  localparam int TMO = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period, high_time;
  logic [R:0]    duty;
  logic          valid, stalled, ovr;

  always #5 clk = ~clk;

  pwm_capture #(.R(R), .CW(CW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .duty(duty), .valid(valid), .stalled(stalled), .ovr(ovr)
  );

  typedef struct { int per; int hi; int exp_duty; } vec_t;
  typedef struct { int per; int hi; int duty; } res_t;

  res_t res_q[$];
  int   ovr_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Result monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (valid) res_q.push_back('{int'(period), int'(high_time), int'(duty)});
      if (ovr) ovr_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input int idx, input int per, input int hi, input int dt);
    if (idx >= res_q.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: only %0d results, expected index %0d", name, res_q.size(), idx);
    end else begin
      check({name, "_period"}, res_q[idx].per, per);
      check({name, "_high"}, res_q[idx].hi, hi);
      check({name, "_duty"}, res_q[idx].duty, dt);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_period(input int p, input int h);
    pwm_in = 1'b1;
    cycles(h);
    pwm_in = 1'b0;
    cycles(p - h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pwm_in = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(5);
  endtask

  task automatic wait_stalled(input string name);
    int k;
    k = 0;
    while (!stalled && k < TMO + 10) begin
      cycles(1);
      k++;
    end
    check(name, int'(stalled), 1);
  endtask

  initial begin
    vec_t vecs[6];
    int   base, base_ovr;

    vecs[0] = '{256, 64, 64};
    vecs[1] = '{1000, 333, 85};
`ifdef PWM_CAP_GLITCH_FILTER_EN
    vecs[2] = '{100, 3, 7};
    vecs[3] = '{100, 97, 248};
`else
    vecs[2] = '{100, 1, 2};
    vecs[3] = '{100, 99, 253};
`endif
    vecs[4] = '{11, 5, 116};
    vecs[5] = '{200, 100, 128};

    do_reset();
    check("reset_period", int'(period), 0);
    check("reset_high", int'(high_time), 0);
    check("reset_duty", int'(duty), 0);
    check("reset_flags", int'({valid, stalled, ovr}), 0);

    // Clean waveforms: three closed periods, each must report identically.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = res_q.size();
      base_ovr = ovr_cnt;
      for (int n = 0; n < 3; n++) drive_period(vecs[v].per, vecs[v].hi);
      pwm_in = 1'b1;
      cycles(vecs[v].hi);
      pwm_in = 1'b0;
      cycles(30);
      check($sformatf("vec%0d_count", v), res_q.size() - base, 3);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - base_ovr, 0);
      for (int i = 0; i < 3; i++)
        check_res($sformatf("vec%0d_res%0d", v, i), base + i, vecs[v].per, vecs[v].hi, vecs[v].exp_duty);
    end

    // Stuck low, then stuck high.
    do_reset();
    base = res_q.size();
    pwm_in = 1'b0;
    wait_stalled("stall_low_flag");
    cycles(20);
    check("stall_low_valids", res_q.size() - base, 1);
    check_res("stall_low", base, TMO, 0, 0);
    pwm_in = 1'b1;
    cycles(6);
    check("stall_clear", int'(stalled), 0);
    base = res_q.size();
    wait_stalled("stall_high_flag");
    cycles(20);
    check("stall_high_valids", res_q.size() - base, 1);
    check_res("stall_high", base, TMO, TMO, 256);

    // Periods shorter than R+3: every other closing edge is dropped.
    do_reset();
    base = res_q.size();
    base_ovr = ovr_cnt;
    for (int n = 0; n < 10; n++) drive_period(6, 3);
    pwm_in = 1'b1;
    cycles(3);
    pwm_in = 1'b0;
    cycles(30);
    check("ovr_pulses", ovr_cnt - base_ovr, 5);
    check("ovr_results", res_q.size() - base, 5);
    for (int i = base; i < res_q.size(); i++) check_res("ovr_res", i, 6, 3, 128);

    // Reset asserted mid-high, released in the low phase.
    do_reset();
    drive_period(500, 100);
    drive_period(500, 100);
    pwm_in = 1'b1;
    cycles(50);
    check("pre_reset_period", int'(period), 500);
    rst = 1'b0;
    #1;
    check("midrst_period", int'(period), 0);
    check("midrst_high", int'(high_time), 0);
    check("midrst_duty", int'(duty), 0);
    check("midrst_flags", int'({valid, stalled, ovr}), 0);
    cycles(50);
    pwm_in = 1'b0;
    cycles(10);
    rst = 1'b1;
    base = res_q.size();
    cycles(390);
    drive_period(500, 100);
    drive_period(500, 100);
    pwm_in = 1'b1;
    cycles(100);
    pwm_in = 1'b0;
    cycles(30);
    check("postrst_count", res_q.size() - base, 2);
    check_res("postrst_first", base, 500, 100, 51);

    // Two-clock glitch inside the low phase.
    do_reset();
    base = res_q.size();
    drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(64);
    pwm_in = 1'b0;
    cycles(86);
    pwm_in = 1'b1;
    cycles(2);
    pwm_in = 1'b0;
    cycles(104);
    drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(64);
    pwm_in = 1'b0;
    cycles(30);
`ifdef PWM_CAP_GLITCH_FILTER_EN
    check("glitch_count", res_q.size() - base, 3);
    for (int i = 0; i < 3; i++) check_res("glitch_res", base + i, 256, 64, 64);
`else
    check("glitch_count", res_q.size() - base, 4);
    check_res("glitch_res0", base, 256, 64, 64);
    check_res("glitch_res1", base + 1, 150, 64, 109);
    check_res("glitch_res2", base + 2, 106, 2, 4);
    check_res("glitch_res3", base + 3, 256, 64, 64);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
